// File: rtl/wb_arbiter2_pkg.sv
// Shared types and constants for the two-master wishbone arbiter.
// State encodings are 2 bits and are exported on the arbiter's debug port.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// Bus watchdog: counts cycles a strobe waits for ACK and raises a one-cycle
// error pulse on the cycle after the count reaches TIMEOUT-1 without an ACK.
module wb_watchdog #(
  parameter int TIMEOUT = 256,
  parameter int TO_BITS = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic err
);

  localparam bit                 WD_EN   = (TIMEOUT != 0);
  localparam logic [TO_BITS-1:0] WD_LAST = TO_BITS'(TIMEOUT - 1);
  localparam logic [TO_BITS-1:0] WD_SAT  = TO_BITS'(TIMEOUT);

  logic [TO_BITS-1:0] wdog;
  logic               err_pend;
  logic               restart;

  // An ACK arriving on the expiry cycle restarts the count, so it wins over the error.
  assign restart = clr | ~stb | ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog     <= '0;
      err_pend <= 1'b0;
    end else begin
      if (restart) begin
        wdog <= '0;
      end else if (wdog != WD_SAT) begin
        wdog <= wdog + 1'b1;
      end

      if (err_pend || clr) begin
        err_pend <= 1'b0;
      end else if (WD_EN && !restart && (wdog == WD_LAST)) begin
        err_pend <= 1'b1;
      end
    end
  end

  assign err = err_pend;

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter sharing one wishbone slave between two masters; the grant
// is held for the whole CYC so bursts pass through unbroken.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int WB_ADDR_BITS = 32,
  parameter int WORD_BYTES   = 4,
  parameter int TIMEOUT      = 256,
  parameter int TO_BITS      = 9,
  localparam int WORD_BITS   = 8 * WORD_BYTES
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,

  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic [WB_ADDR_BITS-3:0] m0_addr_i,
  input  logic [2:0]              m0_cti_i,
  input  logic [1:0]              m0_bte_i,
  input  logic [WORD_BYTES-1:0]   m0_sel_i,
  input  logic                    m0_we_i,
  input  logic [WORD_BITS-1:0]    m0_data_i,
  output logic [WORD_BITS-1:0]    m0_data_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,

  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic [WB_ADDR_BITS-3:0] m1_addr_i,
  input  logic [2:0]              m1_cti_i,
  input  logic [1:0]              m1_bte_i,
  input  logic [WORD_BYTES-1:0]   m1_sel_i,
  input  logic                    m1_we_i,
  input  logic [WORD_BITS-1:0]    m1_data_i,
  output logic [WORD_BITS-1:0]    m1_data_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,

  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic [WB_ADDR_BITS-3:0] s_addr_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  output logic [WORD_BYTES-1:0]   s_sel_o,
  output logic                    s_we_o,
  output logic [WORD_BITS-1:0]    s_data_o,
  input  logic [WORD_BITS-1:0]    s_data_i,
  input  logic                    s_ack_i,

  output logic [1:0]              dbg_state
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic       err_pend;
  logic       wd_clr;

  // Handshake: STB is a request held by the granted master until it sees ACK or
  // ERR in the same cycle; ACK/ERR reach only the granted master.

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // On a tie the master that did not own the previous bus cycle wins.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_addr_o = '0;
    s_cti_o  = WB_CTI_CLASSIC;
    s_bte_o  = WB_BTE_LINEAR;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_data_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      ST_GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~err_pend;
        s_addr_o = m0_addr_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_data_o = m0_data_i;
        m0_ack_o = s_ack_i;
        m0_err_o = err_pend;
      end
      ST_GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~err_pend;
        s_addr_o = m1_addr_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_data_o = m1_data_i;
        m1_ack_o = s_ack_i;
        m1_err_o = err_pend;
      end
      default: ;
    endcase
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign dbg_state = state;
  assign wd_clr    = (state == ST_IDLE);

  // The error cycle forces s_stb_o low, which also restarts the count.
  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_wdog (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .stb (s_stb_o),
    .ack (s_ack_i),
    .clr (wd_clr),
    .err (err_pend)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: cycle-by-cycle vector table plus hand-written
// burst and mid-burst reset sequences. Watchdog TIMEOUT is 4.
module tb_wb_arbiter2;
  import wb_arbiter2_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;

  localparam logic [AW-1:0] M0_ADDR  = 30'h10;
  localparam logic [AW-1:0] M1_ADDR  = 30'h20;
  localparam logic [DW-1:0] M0_DATA  = 32'hA5A5_0000;
  localparam logic [DW-1:0] M1_DATA  = 32'h5A5A_1111;
  localparam logic [SW-1:0] M0_SEL   = 4'hF;
  localparam logic [SW-1:0] M1_SEL   = 4'h3;
  localparam logic [1:0]    M1_BTE   = 2'b01;
  localparam logic [2:0]    CTI_INCR = 3'b010;
  localparam logic [2:0]    CTI_EOB  = 3'b111;

  logic          wb_clk_i, wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
  logic [AW-1:0] m0_addr_i;
  logic [2:0]    m0_cti_i;
  logic [1:0]    m0_bte_i;
  logic [SW-1:0] m0_sel_i;
  logic [DW-1:0] m0_data_i, m0_data_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [AW-1:0] m1_addr_i;
  logic [2:0]    m1_cti_i;
  logic [1:0]    m1_bte_i;
  logic [SW-1:0] m1_sel_i;
  logic [DW-1:0] m1_data_i, m1_data_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0] s_addr_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_data_o, s_data_i;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  wb_arbiter2 #(
    .WB_ADDR_BITS (32),
    .WORD_BYTES   (4),
    .TIMEOUT      (4),
    .TO_BITS      (3)
  ) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_addr_i (m0_addr_i),
    .m0_cti_i (m0_cti_i), .m0_bte_i (m0_bte_i), .m0_sel_i (m0_sel_i),
    .m0_we_i (m0_we_i), .m0_data_i (m0_data_i), .m0_data_o (m0_data_o),
    .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_addr_i (m1_addr_i),
    .m1_cti_i (m1_cti_i), .m1_bte_i (m1_bte_i), .m1_sel_i (m1_sel_i),
    .m1_we_i (m1_we_i), .m1_data_i (m1_data_i), .m1_data_o (m1_data_o),
    .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_addr_o (s_addr_o),
    .s_cti_o (s_cti_o), .s_bte_o (s_bte_o), .s_sel_o (s_sel_o),
    .s_we_o (s_we_o), .s_data_o (s_data_o), .s_data_i (s_data_i),
    .s_ack_i (s_ack_i), .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- vector table ----------------
  // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
  // ex = {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}
  typedef struct packed {
    bit         rst;
    bit [4:0]   in;
    bit [5:0]   ex;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit r, input bit [4:0] in, input bit [5:0] ex,
                             input logic [1:0] st);
    vec_t t;
    t.rst = r;
    t.in  = in;
    t.ex  = ex;
    t.st  = st;
    return t;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [79:0] mux_exp(input logic [1:0] st);
    case (st)
      ST_GNT0: return {M0_ADDR, WB_CTI_CLASSIC, WB_BTE_LINEAR, M0_SEL, 1'b0, M0_DATA};
      ST_GNT1: return {M1_ADDR, WB_CTI_CLASSIC, M1_BTE, M1_SEL, 1'b1, M1_DATA};
      default: return '0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drop_all();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    drop_all();
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("reset outputs", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 6'b0);
    chk("reset state", dbg_state, ST_IDLE);
    step();
  endtask

  task automatic apply_row(input int idx, input vec_t r);
    if (r.rst) do_reset();
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = r.in;
    s_data_i = $urandom;
    @(negedge wb_clk_i);
    chk($sformatf("row%0d cyc_stb", idx), {s_cyc_o, s_stb_o}, r.ex[5:4]);
    chk($sformatf("row%0d ack", idx), {m0_ack_o, m1_ack_o}, r.ex[3:2]);
    chk($sformatf("row%0d err", idx), {m0_err_o, m1_err_o}, r.ex[1:0]);
    chk($sformatf("row%0d state", idx), dbg_state, r.st);
    chk($sformatf("row%0d mux", idx),
        {s_addr_o, s_cti_o, s_bte_o, s_sel_o, s_we_o, s_data_o}, mux_exp(r.st));
    chk($sformatf("row%0d rdata", idx), {m0_data_o, m1_data_o}, {s_data_i, s_data_i});
    step();
  endtask

  // ---------------- test ----------------
  initial begin
    wb_rst_i  = 1'b1;
    drop_all();
    m0_addr_i = M0_ADDR; m0_cti_i = WB_CTI_CLASSIC; m0_bte_i = WB_BTE_LINEAR;
    m0_sel_i  = M0_SEL;  m0_we_i  = 1'b0;           m0_data_i = M0_DATA;
    m1_addr_i = M1_ADDR; m1_cti_i = WB_CTI_CLASSIC; m1_bte_i = M1_BTE;
    m1_sel_i  = M1_SEL;  m1_we_i  = 1'b1;           m1_data_i = M1_DATA;
    s_data_i  = '0;

    // single m0 read, then back-to-back m0 cycles with the dead IDLE cycle
    tbl.push_back(v(1, 5'b11000, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b11000, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b11001, 6'b111000, ST_GNT0));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_GNT0));
    tbl.push_back(v(0, 5'b11000, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b11000, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_GNT0));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_IDLE));
    // tie after reset -> m0, then m1, then alternating ties
    tbl.push_back(v(1, 5'b11110, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b11111, 6'b111000, ST_GNT0));
    tbl.push_back(v(0, 5'b00110, 6'b000000, ST_GNT0));
    tbl.push_back(v(0, 5'b00110, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b00111, 6'b110100, ST_GNT1));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_GNT1));
    tbl.push_back(v(0, 5'b11110, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b11110, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_GNT0));
    tbl.push_back(v(0, 5'b11110, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b11110, 6'b110000, ST_GNT1));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_GNT1));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_IDLE));
    // watchdog expiry on m0: err on 5th STB cycle, STB masked; then new STB acked
    tbl.push_back(v(1, 5'b11000, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b11000, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b11000, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b11000, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b11000, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b11000, 6'b100010, ST_GNT0));
    tbl.push_back(v(0, 5'b10000, 6'b100000, ST_GNT0));
    tbl.push_back(v(0, 5'b11000, 6'b110000, ST_GNT0));
    tbl.push_back(v(0, 5'b11001, 6'b111000, ST_GNT0));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_GNT0));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_IDLE));
    // ack on the expiry cycle for m1: ack wins, no err
    tbl.push_back(v(1, 5'b00110, 6'b000000, ST_IDLE));
    tbl.push_back(v(0, 5'b00110, 6'b110000, ST_GNT1));
    tbl.push_back(v(0, 5'b00110, 6'b110000, ST_GNT1));
    tbl.push_back(v(0, 5'b00110, 6'b110000, ST_GNT1));
    tbl.push_back(v(0, 5'b00111, 6'b110100, ST_GNT1));
    tbl.push_back(v(0, 5'b00110, 6'b110000, ST_GNT1));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_GNT1));
    tbl.push_back(v(0, 5'b00000, 6'b000000, ST_IDLE));

    foreach (tbl[i]) apply_row(i, tbl[i]);

    // m1 8-beat incrementing burst with m0 waiting
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = CTI_INCR; m1_addr_i = 30'h40;
    @(negedge wb_clk_i);
    chk("burst start idle", dbg_state, ST_IDLE);
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ecti;
      ecti      = (i == 7) ? CTI_EOB : CTI_INCR;
      m1_addr_i = 30'h40 + 30'(i);
      m1_cti_i  = ecti;
      s_ack_i   = 1'b1;
      @(negedge wb_clk_i);
      chk($sformatf("burst beat%0d state", i), dbg_state, ST_GNT1);
      chk($sformatf("burst beat%0d ack", i), {m0_ack_o, m1_ack_o}, 2'b01);
      chk($sformatf("burst beat%0d addr_cti", i), {s_addr_o, s_cti_o}, {30'h40 + 30'(i), ecti});
      step();
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    m1_cti_i = WB_CTI_CLASSIC; m1_addr_i = M1_ADDR;
    @(negedge wb_clk_i);
    chk("burst release", {dbg_state, s_cyc_o, m0_ack_o}, {ST_GNT1, 1'b0, 1'b0});
    step();
    @(negedge wb_clk_i);
    chk("burst dead cycle", {dbg_state, s_cyc_o}, {ST_IDLE, 1'b0});
    step();
    @(negedge wb_clk_i);
    chk("burst then m0", {dbg_state, s_cyc_o, s_addr_o}, {ST_GNT0, 1'b1, M0_ADDR});
    step();
    drop_all();
    step();
    step();

    // reset in the middle of an m1 burst
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = CTI_INCR;
    step();
    s_ack_i = 1'b1;
    @(negedge wb_clk_i);
    chk("rst burst beat", {dbg_state, m1_ack_o}, {ST_GNT1, 1'b1});
    step();
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0; s_ack_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    @(negedge wb_clk_i);
    chk("rst mid burst", {dbg_state, s_cyc_o, s_stb_o, m1_ack_o}, {ST_IDLE, 3'b000});
    step();
    @(negedge wb_clk_i);
    chk("rst tie to m0", {dbg_state, s_cyc_o, s_addr_o}, {ST_GNT0, 1'b1, M0_ADDR});
    step();
    drop_all();
    m1_cti_i = WB_CTI_CLASSIC;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
